// File: rtl/kernel_entry_ctrl_if.sv
// Decode-stage trap interface between the pipeline front end and kernel_entry_ctrl.
// The pipeline drives the master side and kernel_entry_ctrl sits on the slave side.
interface kernel_entry_ctrl_if #(
  parameter int unsigned IRQ_W = 4
);
  logic [IRQ_W-1:0] irq;
  logic [IRQ_W-1:0] irq_en;
  logic             syscall;
  logic             eret;
  logic [15:0]      pc_in;
  logic             pipe_empty;
  logic             stall;
  logic             in_kernel;
  logic             pc_load;
  logic [15:0]      pc_vector;
  logic [15:0]      epc;
  logic [3:0]       cause;
  logic             restore;

  modport master (
    output irq, irq_en, syscall, eret, pc_in, pipe_empty,
    input  stall, in_kernel, pc_load, pc_vector, epc, cause, restore
  );

  modport slave (
    input  irq, irq_en, syscall, eret, pc_in, pipe_empty,
    output stall, in_kernel, pc_load, pc_vector, epc, cause, restore
  );
endinterface

// File: rtl/kernel_entry_ctrl.sv
// Sequences user/kernel transitions: drains the pipe, vectors to the handler and,
// on eret, restores the shadowed registers and jumps back to the saved PC.
module kernel_entry_ctrl #(
  parameter logic [15:0] VEC_BASE = 16'h0100,
  parameter int unsigned IRQ_W    = 4
) (
  input logic                clock,
  input logic                reset,
  kernel_entry_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StUser,
    StDrain,
    StEnter,
    StKernel,
    StRestore
  } state_e;

  state_e           state;
  logic [IRQ_W-1:0] pend;
  logic             trig;
  logic [3:0]       cause_nxt;

  assign pend = bus.irq & bus.irq_en;
  assign trig = bus.syscall | (|pend);

  // Syscall beats every irq; among irqs the lowest index wins.
  always_comb begin
    cause_nxt = 4'd0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (pend[i]) cause_nxt = 4'(i + 2);
    end
    if (bus.syscall) cause_nxt = 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= StUser;
      bus.stall     <= 1'b0;
      bus.in_kernel <= 1'b0;
      bus.pc_load   <= 1'b0;
      bus.restore   <= 1'b0;
      bus.pc_vector <= 16'h0000;
      bus.epc       <= 16'h0000;
      bus.cause     <= 4'd0;
    end else begin
      bus.pc_load <= 1'b0;
      bus.restore <= 1'b0;
      unique case (state)
        StUser: begin
          bus.in_kernel <= 1'b0;
          bus.stall     <= 1'b0;
          if (trig) begin
            bus.epc   <= bus.pc_in;
            bus.cause <= cause_nxt;
            bus.stall <= 1'b1;
            state     <= StDrain;
          end
        end
        StDrain: begin
          // Stay out of kernel mode so the backup block captures the last user values.
          if (bus.pipe_empty) begin
            bus.in_kernel <= 1'b1;
            bus.pc_load   <= 1'b1;
            bus.pc_vector <= VEC_BASE + {8'h00, bus.cause, 4'h0};
            state         <= StEnter;
          end
        end
        StEnter: begin
          bus.stall <= 1'b0;
          state     <= StKernel;
        end
        StKernel: begin
          if (bus.eret) begin
            bus.stall     <= 1'b1;
            bus.restore   <= 1'b1;
            bus.pc_load   <= 1'b1;
            bus.pc_vector <= bus.epc;
            state         <= StRestore;
          end
        end
        StRestore: begin
          bus.in_kernel <= 1'b0;
          bus.stall     <= 1'b0;
          bus.cause     <= 4'd0;
          state         <= StUser;
        end
        default: state <= StUser;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_entry_ctrl.sv
// Directed bench for kernel_entry_ctrl; a second instance with a high vector base
// shares the same stimulus to exercise handler-address wrap-around.
module tb_kernel_entry_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  kernel_entry_ctrl_if #(.IRQ_W(4)) bus ();
  kernel_entry_ctrl_if #(.IRQ_W(4)) bus_w ();

  assign bus_w.irq        = bus.irq;
  assign bus_w.irq_en     = bus.irq_en;
  assign bus_w.syscall    = bus.syscall;
  assign bus_w.eret       = bus.eret;
  assign bus_w.pc_in      = bus.pc_in;
  assign bus_w.pipe_empty = bus.pipe_empty;

  kernel_entry_ctrl #(.VEC_BASE(16'h0100), .IRQ_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  kernel_entry_ctrl #(.VEC_BASE(16'hFFF0), .IRQ_W(4)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stall"}, 32'(bus.stall), 32'd0);
    chk({tag, ".in_kernel"}, 32'(bus.in_kernel), 32'd0);
    chk({tag, ".pc_load"}, 32'(bus.pc_load), 32'd0);
    chk({tag, ".restore"}, 32'(bus.restore), 32'd0);
    chk({tag, ".epc"}, 32'(bus.epc), 32'd0);
    chk({tag, ".cause"}, 32'(bus.cause), 32'd0);
    chk({tag, ".pc_vector"}, 32'(bus.pc_vector), 32'd0);
  endtask

  // From KERNEL: eret -> RESTORE -> USER.
  task automatic go_home();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick();
  endtask

  initial begin
    bus.irq        = '0;
    bus.irq_en     = '0;
    bus.syscall    = 1'b0;
    bus.eret       = 1'b0;
    bus.pc_in      = 16'h0000;
    bus.pipe_empty = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b1;

    // Syscall entry and return, with an enabled irq ignored while in KERNEL.
    bus.pc_in   = 16'h0042;
    bus.syscall = 1'b1;
    tick();
    bus.syscall = 1'b0;
    chk("sys.drain.stall", 32'(bus.stall), 32'd1);
    chk("sys.drain.in_kernel", 32'(bus.in_kernel), 32'd0);
    chk("sys.drain.pc_load", 32'(bus.pc_load), 32'd0);
    chk("sys.epc", 32'(bus.epc), 32'h0042);
    chk("sys.cause", 32'(bus.cause), 32'd1);
    tick();
    chk("sys.enter.pc_load", 32'(bus.pc_load), 32'd1);
    chk("sys.enter.pc_vector", 32'(bus.pc_vector), 32'h0110);
    chk("sys.enter.in_kernel", 32'(bus.in_kernel), 32'd1);
    chk("sys.enter.stall", 32'(bus.stall), 32'd1);
    bus.irq    = 4'b0001;
    bus.irq_en = 4'b0001;
    tick();
    chk("sys.kernel.pc_load", 32'(bus.pc_load), 32'd0);
    chk("sys.kernel.stall", 32'(bus.stall), 32'd0);
    tick();
    chk("kernel.irq_ignored.stall", 32'(bus.stall), 32'd0);
    chk("kernel.irq_ignored.cause", 32'(bus.cause), 32'd1);
    chk("kernel.irq_ignored.in_kernel", 32'(bus.in_kernel), 32'd1);
    bus.irq     = 4'b0000;
    bus.eret    = 1'b1;
    bus.syscall = 1'b1;
    tick();
    bus.eret    = 1'b0;
    bus.syscall = 1'b0;
    chk("ret.restore", 32'(bus.restore), 32'd1);
    chk("ret.pc_load", 32'(bus.pc_load), 32'd1);
    chk("ret.pc_vector", 32'(bus.pc_vector), 32'h0042);
    chk("ret.stall", 32'(bus.stall), 32'd1);
    chk("ret.in_kernel", 32'(bus.in_kernel), 32'd1);
    tick();
    chk("user.in_kernel", 32'(bus.in_kernel), 32'd0);
    chk("user.cause", 32'(bus.cause), 32'd0);
    chk("user.restore", 32'(bus.restore), 32'd0);
    chk("user.pc_load", 32'(bus.pc_load), 32'd0);
    chk("user.epc_held", 32'(bus.epc), 32'h0042);
    chk("user.stall", 32'(bus.stall), 32'd0);

    // Priority: syscall over irqs (eret alongside in USER is ignored), then lowest irq.
    bus.irq_en  = 4'b1111;
    bus.irq     = 4'b0110;
    bus.syscall = 1'b1;
    bus.eret    = 1'b1;
    bus.pc_in   = 16'h1234;
    tick();
    bus.syscall = 1'b0;
    bus.eret    = 1'b0;
    bus.irq     = 4'b0000;
    chk("prio.sys.cause", 32'(bus.cause), 32'd1);
    chk("prio.sys.epc", 32'(bus.epc), 32'h1234);
    tick();
    tick();
    go_home();
    bus.irq = 4'b0110;
    tick();
    bus.irq = 4'b0000;
    chk("prio.irq.cause", 32'(bus.cause), 32'd3);
    tick();
    chk("prio.irq.pc_load", 32'(bus.pc_load), 32'd1);
    chk("prio.irq.pc_vector", 32'(bus.pc_vector), 32'h0130);
    tick();
    go_home();

    // Masked irq stays in USER; enabled irq with pipe busy holds DRAIN.
    bus.irq_en = 4'b0000;
    bus.irq    = 4'b0001;
    tick();
    tick();
    chk("mask.stall", 32'(bus.stall), 32'd0);
    chk("mask.cause", 32'(bus.cause), 32'd0);
    bus.pipe_empty = 1'b0;
    bus.irq_en     = 4'b0001;
    bus.pc_in      = 16'h0200;
    tick();
    bus.irq     = 4'b0000;
    bus.syscall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain%0d.stall", i), 32'(bus.stall), 32'd1);
      chk($sformatf("drain%0d.in_kernel", i), 32'(bus.in_kernel), 32'd0);
      chk($sformatf("drain%0d.pc_load", i), 32'(bus.pc_load), 32'd0);
      tick();
    end
    bus.syscall = 1'b0;
    chk("drain.cause_held", 32'(bus.cause), 32'd2);
    chk("drain.epc_held", 32'(bus.epc), 32'h0200);
    bus.pipe_empty = 1'b1;
    tick();
    chk("drain.enter.pc_load", 32'(bus.pc_load), 32'd1);
    chk("drain.enter.pc_vector", 32'(bus.pc_vector), 32'h0120);
    chk("drain.enter.in_kernel", 32'(bus.in_kernel), 32'd1);
    tick();
    go_home();

    // Reset mid-DRAIN.
    bus.pipe_empty = 1'b0;
    bus.syscall    = 1'b1;
    tick();
    bus.syscall = 1'b0;
    chk("rst_drain.pre.stall", 32'(bus.stall), 32'd1);
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    bus.pipe_empty = 1'b1;
    chk_idle("rst_drain");
    tick();
    chk("rst_drain.after.pc_load", 32'(bus.pc_load), 32'd0);
    chk("rst_drain.after.stall", 32'(bus.stall), 32'd0);

    // Reset mid-RESTORE.
    bus.syscall = 1'b1;
    bus.pc_in   = 16'h0777;
    tick();
    bus.syscall = 1'b0;
    tick();
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("rst_restore.pre.restore", 32'(bus.restore), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle("rst_restore");
    tick();
    chk("rst_restore.after.restore", 32'(bus.restore), 32'd0);

    // Vector wrap on the high-base instance via irq[3].
    bus.irq_en = 4'b1000;
    bus.irq    = 4'b1000;
    tick();
    bus.irq = 4'b0000;
    chk("wrap.cause", 32'(bus_w.cause), 32'd5);
    tick();
    chk("wrap.pc_load", 32'(bus_w.pc_load), 32'd1);
    chk("wrap.pc_vector", 32'(bus_w.pc_vector), 32'h0040);
    chk("wrap.base_pc_vector", 32'(bus.pc_vector), 32'h0150);
    tick();
    go_home();
    chk("wrap.home.in_kernel", 32'(bus_w.in_kernel), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
